// File: rtl/btb_assoc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | btb_assoc : set-associative BTB, 2-bit counters, true-LRU, taken-only      |
// |             allocation, flush; counters optional via `BTB_STATS_EN.        |
// | Revision  : 1.0                                                          |
// +--------------------------------------------------------------------------+
module btb_assoc #(
  parameter int XLEN = 32,
  parameter int SETS = 32,
  parameter int WAYS = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            lookup_req,
  input  logic [XLEN-1:0] lookup_pc,
  output logic            lookup_resp,
  output logic            lookup_hit,
  output logic            lookup_taken,
  output logic [XLEN-1:0] lookup_target,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_taken,
  input  logic            flush,
  output logic [31:0]     stat_lookups,
  output logic [31:0]     stat_hits
);
  localparam int IDX_W = $clog2(SETS);
  localparam int AGE_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int TAG_W = XLEN - IDX_W - 2;
  localparam logic [AGE_W-1:0] AGE_LRU = AGE_W'(WAYS - 1);
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RESP = 1'b1;

  logic             valid_q  [SETS][WAYS];
  logic             valid_d  [SETS][WAYS];
  logic [TAG_W-1:0] tag_q    [SETS][WAYS];
  logic [TAG_W-1:0] tag_d    [SETS][WAYS];
  logic [XLEN-1:0]  target_q [SETS][WAYS];
  logic [XLEN-1:0]  target_d [SETS][WAYS];
  logic [1:0]       ctr_q    [SETS][WAYS];
  logic [1:0]       ctr_d    [SETS][WAYS];
  logic [AGE_W-1:0] age_q    [SETS][WAYS];
  logic [AGE_W-1:0] age_d    [SETS][WAYS];

  logic [0:0]      state_q, state_d;
  logic            res_hit_q, res_hit_d, res_taken_q, res_taken_d;
  logic [XLEN-1:0] res_target_q, res_target_d;

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic             lk_hit, lk_taken;
  logic [XLEN-1:0]  lk_target;
  logic             up_hit, inv_found, do_mru;
  logic [AGE_W-1:0] up_way, inv_way, lru_way, mru_way, old_age;
  logic             unused_pc_bits;

  assign lk_idx = lookup_pc[IDX_W+1:2];
  assign lk_tag = lookup_pc[XLEN-1:IDX_W+2];
  assign up_idx = upd_pc[IDX_W+1:2];
  assign up_tag = upd_pc[XLEN-1:IDX_W+2];
  assign unused_pc_bits = ^{lookup_pc[1:0], upd_pc[1:0]};

  // Lookup reads pre-edge state, so a same-edge update is never visible here.
  always_comb begin
    lk_hit    = 1'b0;
    lk_taken  = 1'b0;
    lk_target = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[lk_idx][w] && tag_q[lk_idx][w] == lk_tag) begin
        lk_hit    = 1'b1;
        lk_taken  = ctr_q[lk_idx][w][1];
        lk_target = target_q[lk_idx][w];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = ST_IDLE;
    case (state_q)
      ST_IDLE: state_d = (lookup_req && !flush) ? ST_RESP : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    lookup_resp   = (state_q == ST_RESP) && !flush;
    lookup_hit    = lookup_resp & res_hit_q;
    lookup_taken  = lookup_resp & res_taken_q;
    lookup_target = lookup_resp ? res_target_q : '0;
  end

  always_comb begin
    res_hit_d    = res_hit_q;
    res_taken_d  = res_taken_q;
    res_target_d = res_target_q;
    if (state_q == ST_IDLE && lookup_req && !flush) begin
      res_hit_d    = lk_hit;
      res_taken_d  = lk_taken;
      res_target_d = lk_target;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_hit_q    <= 1'b0;
      res_taken_q  <= 1'b0;
      res_target_q <= '0;
    end else begin
      res_hit_q    <= res_hit_d;
      res_taken_q  <= res_taken_d;
      res_target_q <= res_target_d;
    end
  end

  always_comb begin
    valid_d   = valid_q;
    tag_d     = tag_q;
    target_d  = target_q;
    ctr_d     = ctr_q;
    age_d     = age_q;
    up_hit    = 1'b0;
    up_way    = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    lru_way   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[up_idx][w] && tag_q[up_idx][w] == up_tag) begin
        up_hit = 1'b1;
        up_way = AGE_W'(w);
      end
      if (!valid_q[up_idx][w] && !inv_found) begin
        inv_found = 1'b1;
        inv_way   = AGE_W'(w);
      end
      if (age_q[up_idx][w] == AGE_LRU) lru_way = AGE_W'(w);
    end
    mru_way = up_hit ? up_way : (inv_found ? inv_way : lru_way);
    old_age = age_q[up_idx][mru_way];
    do_mru  = upd_valid && !flush && (up_hit || upd_taken);

    if (flush) begin
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++)
          valid_d[s][w] = 1'b0;
    end else if (do_mru) begin
      target_d[up_idx][mru_way] = upd_target;
      if (up_hit) begin
        if (upd_taken) begin
          if (ctr_q[up_idx][mru_way] != 2'b11)
            ctr_d[up_idx][mru_way] = ctr_q[up_idx][mru_way] + 2'd1;
        end else if (ctr_q[up_idx][mru_way] != 2'b00) begin
          ctr_d[up_idx][mru_way] = ctr_q[up_idx][mru_way] - 2'd1;
        end
      end else begin
        valid_d[up_idx][mru_way] = 1'b1;
        tag_d[up_idx][mru_way]   = up_tag;
        ctr_d[up_idx][mru_way]   = 2'b10;
      end
      for (int w = 0; w < WAYS; w++)
        if (age_q[up_idx][w] < old_age)
          age_d[up_idx][w] = age_q[up_idx][w] + AGE_W'(1);
      age_d[up_idx][mru_way] = '0;
    end
  end

  // Flop storage so reset and flush both take effect in a single cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          valid_q[s][w]  <= 1'b0;
          tag_q[s][w]    <= '0;
          target_q[s][w] <= '0;
          ctr_q[s][w]    <= 2'b00;
          age_q[s][w]    <= AGE_W'(w);
        end
      end
    end else begin
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      target_q <= target_d;
      ctr_q    <= ctr_d;
      age_q    <= age_d;
    end
  end

`ifdef BTB_STATS_EN
  logic [31:0] stat_lookups_q, stat_lookups_d, stat_hits_q, stat_hits_d;

  always_comb begin
    stat_lookups_d = stat_lookups_q;
    stat_hits_d    = stat_hits_q;
    if (lookup_resp) begin
      if (stat_lookups_q != 32'hFFFF_FFFF) stat_lookups_d = stat_lookups_q + 32'd1;
      if (lookup_hit && stat_hits_q != 32'hFFFF_FFFF) stat_hits_d = stat_hits_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_lookups_q <= '0;
      stat_hits_q    <= '0;
    end else begin
      stat_lookups_q <= stat_lookups_d;
      stat_hits_q    <= stat_hits_d;
    end
  end

  assign stat_lookups = stat_lookups_q;
  assign stat_hits    = stat_hits_q;
`else
  assign stat_lookups = '0;
  assign stat_hits    = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_btb_assoc.sv
`default_nettype none
// Testbench for btb_assoc: directed table, hand-written corner sequences and
// randomized traffic checked against a recency-list reference model.
module tb_btb_assoc;
  localparam int XLEN  = 32;
  localparam int SETS  = 32;
  localparam int WAYS  = 2;
  localparam int IDX_W = 5;
  localparam int OP_UPD = 0, OP_LKP = 1, OP_FLS = 2;

  logic clk = 1'b0, rst_n = 1'b0;
  logic lookup_req = 1'b0, upd_valid = 1'b0, upd_taken = 1'b0, flush = 1'b0;
  logic [XLEN-1:0] lookup_pc = '0, upd_pc = '0, upd_target = '0;
  logic lookup_resp, lookup_hit, lookup_taken;
  logic [XLEN-1:0] lookup_target;
  logic [31:0] stat_lookups, stat_hits;

  int n_pass = 0, n_total = 0;

  always #5 clk = ~clk;

  btb_assoc #(.XLEN(XLEN), .SETS(SETS), .WAYS(WAYS)) dut (
    .clk(clk), .rst_n(rst_n),
    .lookup_req(lookup_req), .lookup_pc(lookup_pc), .lookup_resp(lookup_resp),
    .lookup_hit(lookup_hit), .lookup_taken(lookup_taken), .lookup_target(lookup_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target), .upd_taken(upd_taken),
    .flush(flush), .stat_lookups(stat_lookups), .stat_hits(stat_hits)
  );

  // Reference: each set is a recency-ordered list of live entries, slot 0 = most recent.
  logic [31:0] m_tag [SETS][WAYS];
  logic [31:0] m_tgt [SETS][WAYS];
  int          m_ctr [SETS][WAYS];
  int          m_cnt [SETS];

  function automatic void m_clear();
    for (int s = 0; s < SETS; s++) m_cnt[s] = 0;
  endfunction

  function automatic void m_lookup(input logic [31:0] pc, output logic [33:0] res);
    int s = int'((pc >> 2) % SETS);
    logic [31:0] t = pc >> (IDX_W + 2);
    res = '0;
    for (int i = 0; i < m_cnt[s]; i++)
      if (m_tag[s][i] == t) res = {1'b1, (m_ctr[s][i] >= 2) ? 1'b1 : 1'b0, m_tgt[s][i]};
  endfunction

  function automatic void m_update(input logic [31:0] pc, input logic [31:0] tgt, input bit tk);
    int s = int'((pc >> 2) % SETS);
    logic [31:0] t = pc >> (IDX_W + 2);
    int pos = -1, c;
    for (int i = 0; i < m_cnt[s]; i++) if (m_tag[s][i] == t) pos = i;
    if (pos >= 0) begin
      c = m_ctr[s][pos];
      c = tk ? ((c == 3) ? 3 : c + 1) : ((c == 0) ? 0 : c - 1);
    end else if (tk) begin
      if (m_cnt[s] < WAYS) m_cnt[s]++;
      pos = m_cnt[s] - 1;
      c = 2;
    end else return;
    for (int i = pos; i > 0; i--) begin
      m_tag[s][i] = m_tag[s][i-1];
      m_tgt[s][i] = m_tgt[s][i-1];
      m_ctr[s][i] = m_ctr[s][i-1];
    end
    m_tag[s][0] = t;
    m_tgt[s][0] = tgt;
    m_ctr[s][0] = c;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic do_update(input logic [31:0] pc, input logic [31:0] tgt, input bit tk);
    @(negedge clk);
    upd_valid = 1'b1; upd_pc = pc; upd_target = tgt; upd_taken = tk;
    @(negedge clk);
    upd_valid = 1'b0;
    m_update(pc, tgt, tk);
  endtask

  task automatic do_flush();
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    m_clear();
  endtask

  // Lookup with optional update on the same edge; result is {hit, taken, target}.
  task automatic do_lookup(input logic [31:0] pc, input bit same_upd, input logic [31:0] upc,
                           input logic [31:0] utgt, input bit utk, output logic [33:0] res);
    int waited = 0;
    @(negedge clk);
    lookup_req = 1'b1; lookup_pc = pc;
    if (same_upd) begin
      upd_valid = 1'b1; upd_pc = upc; upd_target = utgt; upd_taken = utk;
    end
    @(negedge clk);
    upd_valid = 1'b0;
    if (same_upd) m_update(upc, utgt, utk);
    while (!lookup_resp && waited < 4) begin
      @(negedge clk);
      waited++;
    end
    check("lookup_latency", 64'(waited), 64'd0);
    res = {lookup_hit, lookup_taken, lookup_target};
    lookup_req = 1'b0;
  endtask

  typedef struct {
    int          op;
    logic [31:0] pc;
    logic [31:0] tgt;
    bit          tk;
    logic [33:0] exp;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(input int op, input logic [31:0] pc, input logic [31:0] tgt,
                              input bit tk, input logic [33:0] exp);
    vec_t v;
    v.op = op; v.pc = pc; v.tgt = tgt; v.tk = tk; v.exp = exp;
    return v;
  endfunction

  initial begin
    logic [33:0] res, exp;
    logic [31:0] pc, tgt;
    int r;

    m_clear();
    tbl.push_back(mk(OP_UPD, 32'h40, 32'h100, 1, '0));
    tbl.push_back(mk(OP_LKP, 32'h40, 0, 0, {2'b11, 32'h100}));
    tbl.push_back(mk(OP_UPD, 32'h40, 32'h100, 0, '0));
    tbl.push_back(mk(OP_LKP, 32'h40, 0, 0, {2'b10, 32'h100}));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(OP_UPD, 32'h40, 32'h100, 1, '0));
    tbl.push_back(mk(OP_LKP, 32'h40, 0, 0, {2'b11, 32'h100}));
    tbl.push_back(mk(OP_UPD, 32'h40, 32'h100, 0, '0));
    tbl.push_back(mk(OP_LKP, 32'h40, 0, 0, {2'b11, 32'h100}));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(OP_UPD, 32'h40, 32'h100, 0, '0));
    tbl.push_back(mk(OP_LKP, 32'h40, 0, 0, {2'b10, 32'h100}));
    tbl.push_back(mk(OP_UPD, 32'h80, 32'h180, 0, '0));
    tbl.push_back(mk(OP_LKP, 32'h80, 0, 0, 34'h0));
    tbl.push_back(mk(OP_UPD, 32'h80, 32'h180, 1, '0));
    tbl.push_back(mk(OP_LKP, 32'h80, 0, 0, {2'b11, 32'h180}));
    tbl.push_back(mk(OP_FLS, 0, 0, 0, '0));
    tbl.push_back(mk(OP_LKP, 32'h80, 0, 0, 34'h0));
    tbl.push_back(mk(OP_UPD, 32'h40, 32'h100, 1, '0));
    tbl.push_back(mk(OP_UPD, 32'hC0, 32'h200, 1, '0));
    tbl.push_back(mk(OP_UPD, 32'h40, 32'h100, 1, '0));
    tbl.push_back(mk(OP_UPD, 32'h140, 32'h300, 1, '0));
    tbl.push_back(mk(OP_LKP, 32'hC0, 0, 0, 34'h0));
    tbl.push_back(mk(OP_LKP, 32'h40, 0, 0, {2'b11, 32'h100}));
    tbl.push_back(mk(OP_LKP, 32'h140, 0, 0, {2'b11, 32'h300}));

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_outputs", {lookup_resp, lookup_hit, lookup_taken, lookup_target}, '0);
    check("reset_stats", {stat_lookups, stat_hits}, '0);
    rst_n = 1'b1;

    // First lookup: response one cycle later, held request not re-served
    @(negedge clk);
    lookup_req = 1'b1; lookup_pc = 32'h40;
    @(negedge clk);
    check("first_resp", {lookup_resp, lookup_hit, lookup_taken, lookup_target}, {3'b100, 32'h0});
    @(negedge clk);
    check("held_req_no_second_resp", lookup_resp, 1'b0);
    lookup_req = 1'b0;

    foreach (tbl[i]) begin
      case (tbl[i].op)
        OP_UPD: do_update(tbl[i].pc, tbl[i].tgt, tbl[i].tk);
        OP_FLS: do_flush();
        default: begin
          do_lookup(tbl[i].pc, 0, 0, 0, 0, res);
          check($sformatf("tbl[%0d] lookup 0x%0h", i, tbl[i].pc), res, tbl[i].exp);
        end
      endcase
    end

    // Same-edge lookup and update on an empty BTB
    do_flush();
    do_lookup(32'h40, 1, 32'h40, 32'h500, 1, res);
    check("same_edge_lookup", res, 34'h0);
    do_lookup(32'h40, 0, 0, 0, 0, res);
    check("after_same_edge", res, {2'b11, 32'h500});

    // Flush while a response is pending
    @(negedge clk);
    lookup_req = 1'b1; lookup_pc = 32'h40;
    @(negedge clk);
    flush = 1'b1;
    #1;
    check("flush_abort_resp", {lookup_resp, lookup_hit, lookup_taken, lookup_target}, '0);
    @(negedge clk);
    flush = 1'b0; lookup_req = 1'b0;
    m_clear();
    check("flush_abort_idle", lookup_resp, 1'b0);
    do_lookup(32'h40, 0, 0, 0, 0, res);
    check("after_flush_miss", res, 34'h0);

    // Reset asserted mid-response
    do_update(32'h40, 32'h600, 1);
    @(negedge clk);
    lookup_req = 1'b1; lookup_pc = 32'h40;
    @(negedge clk);
    check("pre_reset_resp", {lookup_resp, lookup_hit, lookup_target}, {2'b11, 32'h600});
    rst_n = 1'b0;
    #1;
    check("reset_mid_resp", {lookup_resp, lookup_hit, lookup_taken, lookup_target}, '0);
    @(negedge clk);
    lookup_req = 1'b0;
    check("reset_hold", lookup_resp, 1'b0);
    rst_n = 1'b1;
    m_clear();
    check("reset_stats_clear", {stat_lookups, stat_hits}, '0);

    // Statistics: three lookups, two hits
    do_update(32'h40, 32'h700, 1);
    do_lookup(32'h40, 0, 0, 0, 0, res);
    check("stat_lkp1", res[33], 1'b1);
    do_lookup(32'hC0, 0, 0, 0, 0, res);
    check("stat_lkp2", res[33], 1'b0);
    do_lookup(32'h40, 0, 0, 0, 0, res);
    check("stat_lkp3", res[33], 1'b1);
    @(negedge clk);
`ifdef BTB_STATS_EN
    check("stat_lookups", stat_lookups, 64'd3);
    check("stat_hits", stat_hits, 64'd2);
`else
    check("stat_lookups_tied", stat_lookups, 64'd0);
    check("stat_hits_tied", stat_hits, 64'd0);
`endif

    // Randomized traffic over 4 tags x 4 sets to force conflicts and evictions
    do_flush();
    for (int it = 0; it < 400; it++) begin
      r   = int'($urandom_range(0, 19));
      pc  = ($urandom_range(0, 3) << (IDX_W + 2)) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
      tgt = $urandom & 32'hFFFF_FFFC;
      if (r == 0) begin
        do_flush();
      end else if (r < 9) begin
        do_update(pc, tgt, $urandom_range(0, 3) != 0);
      end else begin
        m_lookup(pc, exp);
        if (r > 15) begin
          logic [31:0] upc;
          upc = ($urandom_range(0, 3) << (IDX_W + 2)) | ($urandom_range(0, 3) << 2);
          do_lookup(pc, 1, upc, tgt, $urandom_range(0, 1) != 0, res);
        end else begin
          do_lookup(pc, 0, 0, 0, 0, res);
        end
        check($sformatf("rand[%0d] lookup 0x%0h", it, pc), res, exp);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire
